// File: rtl/ysyx_210978_booth_mul_iter_if.sv
// Request/response bundle for the iterative radix-4 Booth multiplier.
interface ysyx_210978_booth_mul_iter_if;
  logic        mul_valid;
  logic        mul_ready;
  logic        flush;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  modport master (
    output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_210978_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, 33 steps (64-bit) or 17 steps (mulw).
// Optional macro YSYX_210978_BOOTH_EARLY_EXIT_EN stops once the remaining multiplier bits are uniform.
module ysyx_210978_booth_mul_iter (
  input logic                          clock,
  input logic                          reset_n,
  ysyx_210978_booth_mul_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [128:0]   x_reg, acc;
  logic [66:0]    y_reg;
  logic [5:0]     cnt;
  logic           is_w;

  logic           accept;
  logic [64:0]    x_ext, y_ext;
  logic [128:0]   x_init;
  logic [66:0]    y_init;
  logic [128:0]   x_dbl, pp;
  logic [66:0]    y_shift;
  logic           last_step;
  logic           acc_unused;

  assign accept = bus.mul_valid & (state == IDLE) & ~bus.flush;

  always_comb begin
    x_ext = '0;
    y_ext = '0;
    if (bus.mulw) begin
      x_ext = {{33{bus.mul_signed[1] & bus.multiplicand[31]}}, bus.multiplicand[31:0]};
      y_ext = {{33{bus.mul_signed[0] & bus.multiplier[31]}}, bus.multiplier[31:0]};
    end else begin
      x_ext = {bus.mul_signed[1] & bus.multiplicand[63], bus.multiplicand};
      y_ext = {bus.mul_signed[0] & bus.multiplier[63], bus.multiplier};
    end
  end

  assign x_init = {{64{x_ext[64]}}, x_ext};
  // two extra sign bits above y so the last triplet is well formed, plus y[-1] = 0
  assign y_init = {y_ext[64], y_ext, 1'b0};

  assign x_dbl = {x_reg[127:0], 1'b0};

  always_comb begin
    pp = '0;
    case (y_reg[2:0])
      3'b001, 3'b010: pp = x_reg;
      3'b011:         pp = x_dbl;
      3'b100:         pp = ~x_dbl + 129'd1;
      3'b101, 3'b110: pp = ~x_reg + 129'd1;
      default:        pp = '0;
    endcase
  end

  assign y_shift = {{2{y_reg[66]}}, y_reg[66:2]};

`ifdef YSYX_210978_BOOTH_EARLY_EXIT_EN
  assign last_step = (cnt == 6'd1) | (&y_shift) | ~(|y_shift);
`else
  assign last_step = (cnt == 6'd1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_reg <= '0;
      y_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      is_w  <= 1'b0;
    end else if (accept) begin
      x_reg <= x_init;
      y_reg <= y_init;
      acc   <= '0;
      cnt   <= bus.mulw ? 6'd17 : 6'd33;
      is_w  <= bus.mulw;
    end else if (state == BUSY && !bus.flush) begin
      acc   <= acc + pp;
      x_reg <= {x_reg[126:0], 2'b00};
      y_reg <= y_shift;
      cnt   <= cnt - 6'd1;
    end
  end

  // top accumulator bit only carries the modulo-2^129 overflow
  assign acc_unused = acc[128];

  assign bus.mul_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result_lo = is_w ? {{32{acc[31]}}, acc[31:0]} : acc[63:0];
  assign bus.result_hi = is_w ? '0 : acc[127:64];

endmodule

// File: tb/tb_ysyx_210978_booth_mul_iter.sv
// Self-checking bench: vector table through a scoreboard, plus stall/flush/reset sequences.
module tb_ysyx_210978_booth_mul_iter;

  typedef struct {
    bit          w;
    bit [1:0]    s;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] hi;
    logic [63:0] lo;
    int          lat;
    int          ee_lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tab[10];
  vec_t sb[$];

  ysyx_210978_booth_mul_iter_if bus();

  ysyx_210978_booth_mul_iter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [127:0] ref_mul(bit w, bit [1:0] s, logic [63:0] x, logic [63:0] y);
    logic [129:0] xe, ye, p;
    if (w) begin
      xe = {{98{s[1] & x[31]}}, x[31:0]};
      ye = {{98{s[0] & y[31]}}, y[31:0]};
    end else begin
      xe = {{66{s[1] & x[63]}}, x};
      ye = {{66{s[0] & y[63]}}, y};
    end
    p = xe * ye;
    if (w) return {64'h0, {32{p[31]}}, p[31:0]};
    return p[127:0];
  endfunction

  function automatic vec_t mk(bit w, bit [1:0] s, logic [63:0] x, logic [63:0] y,
                              logic [63:0] hi, logic [63:0] lo, int ee);
    vec_t v;
    v.w = w; v.s = s; v.x = x; v.y = y; v.hi = hi; v.lo = lo;
    v.lat = w ? 17 : 33;
    v.ee_lat = ee;
    return v;
  endfunction

  function automatic vec_t mk_model(bit w, bit [1:0] s, logic [63:0] x, logic [63:0] y);
    logic [127:0] p;
    p = ref_mul(w, s, x, y);
    return mk(w, s, x, y, p[127:64], p[63:0], 0);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle_garbage();
    bus.mulw         = 1'($urandom);
    bus.mul_signed   = 2'($urandom);
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
  endtask

  task automatic accept_op(input vec_t v);
    int n;
    n = 0;
    while (!bus.mul_ready && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk("ready_before_accept", 128'(bus.mul_ready), 128'(1));
    bus.mul_valid    = 1'b1;
    bus.mulw         = v.w;
    bus.mul_signed   = v.s;
    bus.multiplicand = v.x;
    bus.multiplier   = v.y;
    @(posedge clock); #1;
    bus.mul_valid = 1'b0;
    drive_idle_garbage();
  endtask

  task automatic do_op(input vec_t v, input int stall);
    vec_t e;
    int n;
    accept_op(v);
    sb.push_back(v);
    chk("busy_ready_low", 128'(bus.mul_ready), 128'(0));
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clock); #1; n++;
    end
    e = sb.pop_front();
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 128'(bus.out_valid), 128'(1));
      return;
    end
    chk("result_hi", 128'(bus.result_hi), 128'(e.hi));
    chk("result_lo", 128'(bus.result_lo), 128'(e.lo));
`ifdef YSYX_210978_BOOTH_EARLY_EXIT_EN
    if (e.ee_lat != 0) chk("latency_early", 128'(n), 128'(e.ee_lat));
    else               chk("latency_bound", 128'(n <= e.lat), 128'(1));
`else
    chk("latency", 128'(n), 128'(e.lat));
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_result_hi", 128'(bus.result_hi), 128'(e.hi));
      chk("stall_result_lo", 128'(bus.result_lo), 128'(e.lo));
      chk("stall_mul_ready", 128'(bus.mul_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("post_handshake_valid", 128'(bus.out_valid), 128'(0));
    chk("post_handshake_ready", 128'(bus.mul_ready), 128'(1));
  endtask

  task automatic watch_silent(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (bus.out_valid) seen++;
    end
    chk(nm, 128'(seen), 128'(0));
  endtask

  initial begin
    vec_t v56;

    tab[0] = mk(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 2);
    tab[1] = mk(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 0);
    tab[2] = mk(1'b1, 2'b11, 64'h0000_0000_8000_0000, 64'd2,
                64'h0, 64'h0000_0000_0000_0000, 0);
    tab[3] = mk(1'b1, 2'b11, 64'h0000_0000_4000_0000, 64'd2,
                64'h0, 64'hFFFF_FFFF_8000_0000, 0);
    tab[4] = mk(1'b0, 2'b11, 64'd9, 64'd1, 64'h0, 64'd9, 1);
    tab[5] = mk(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 0);
    tab[6] = mk_model(1'b0, 2'b11, {$urandom, $urandom}, {$urandom, $urandom});
    tab[7] = mk_model(1'b0, 2'b01, {$urandom, $urandom}, {$urandom, $urandom});
    tab[8] = mk_model(1'b1, 2'b00, {$urandom, $urandom}, {$urandom, $urandom});
    tab[9] = mk_model(1'b1, 2'b10, {$urandom, $urandom}, {$urandom, $urandom});
    v56    = mk(1'b0, 2'b11, 64'd5, 64'd6, 64'h0, 64'd30, 0);

    bus.mul_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_idle_garbage();

    #1;
    chk("reset_mul_ready", 128'(bus.mul_ready), 128'(1));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_result_hi", 128'(bus.result_hi), 128'(0));
    chk("reset_result_lo", 128'(bus.result_lo), 128'(0));
    #20;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 10; i++) do_op(tab[i], 0);

    // out_ready withheld for 10 cycles in DONE
    do_op(v56, 10);

    // flush during the fifth BUSY step
    accept_op(mk(1'b0, 2'b11, 64'h0123_4567_89AB_CDEF, 64'h1234_5678_9ABC_DEF1, 64'h0, 64'h0, 0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
    end
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_mul_ready", 128'(bus.mul_ready), 128'(1));
    watch_silent("flush_no_output", 40);
    do_op(v56, 0);

    // flush beats a simultaneous request in IDLE
    bus.mul_valid = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clock); #1;
    bus.mul_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_blocks_accept", 128'(bus.mul_ready), 128'(1));

    // asynchronous reset mid-BUSY
    accept_op(mk(1'b0, 2'b00, 64'hDEAD_BEEF_0000_1111, 64'h7777_0000_3333_5555, 64'h0, 64'h0, 0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_mul_ready", 128'(bus.mul_ready), 128'(1));
    chk("areset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("areset_result_hi", 128'(bus.result_hi), 128'(0));
    chk("areset_result_lo", 128'(bus.result_lo), 128'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    watch_silent("reset_no_output", 40);
    do_op(v56, 0);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
